combo_lock_fsm: RTL and testbench
=================================

// Module: combo_lock_fsm
// PURPOSE
//  Parametrised combination-lock controller for the Basys board lock design.
//  Collects DIGITS entries of DIGIT_W bits from the switches on debounced enter pulses and compares them to a stored code.
//  Tracks failed attempts and locks out after MAX_TRIES.
//  Supports re-programming the code while open. Sits between the button debouncers and the LED/seven-segment drivers.
// PARAMETERS
//  DIGITS          4                 code length in digits (>=1)
//  DIGIT_W         4                 bits per digit (switch slice width)
//  MAX_TRIES       3                 failed attempts allowed before lockout (>=1)
//  LOCKOUT_CYCLES  100_000_000       lockout duration in clk cycles (1 s @ 100 MHz)
//  DEFAULT_CODE    16'h1234          reset code, DIGITS*DIGIT_W bits, digit 0 in MSBs
// PORTS
//  clk         in   1                    board clock, all logic rising-edge
//  rst         in   1                    asynchronous, active-high reset
//  digit_in    in   DIGIT_W              current digit value from switches
//  enter       in   1                    1-cycle pulse: accept digit_in
//  clear       in   1                    1-cycle pulse: discard partial entry
//  relock      in   1                    1-cycle pulse: close lock
//  prog        in   1                    level: program-new-code mode request
//  unlocked    out  1                    high while in OPEN or PROG
//  lockout     out  1                    high while in LOCKOUT
//  fail_pulse  out  1                    1-cycle pulse on wrong code
//  idx         out  $clog2(DIGITS+1)     digits entered so far in current entry
//  tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
//  state_o     out  3                    encoded state, for LED debug
// BEHAVIOUR
//  Reset (async, immediate)
//   - state=ENTRY, code=DEFAULT_CODE, idx=0, mismatch=0, tries_left=MAX_TRIES, lockout counter=0.
//   - Outputs: unlocked=0, lockout=0, fail_pulse=0, state_o=0.
//   - Reset mid-operation discards any programmed code, which reverts to DEFAULT_CODE.
//  States: ENTRY=0, CHECK=1, OPEN=2, PROG=3, LOCKOUT=4. All outputs are registered.
//  ENTRY
//   - enter: mismatch |= (digit_in != code digit[idx]); idx++.
//   - enter that makes idx==DIGITS: next state CHECK.
//   - clear: idx=0, mismatch=0, no try consumed.
//   - clear+enter in the same cycle: clear wins, digit is dropped.
//  CHECK (1 cycle, inputs ignored)
//   - !mismatch: go to OPEN; tries_left=MAX_TRIES.
//   - mismatch: fail_pulse=1 for one cycle; tries_left--.
//     - tries_left reaches 0: go to LOCKOUT.
//     - otherwise: go to ENTRY.
//   - idx=0 and mismatch=0 on exit from CHECK.
//  Latency
//   - Final enter in cycle N -> CHECK in N+1 -> unlocked (or fail_pulse) visible in N+2.
//  OPEN
//   - relock: go to ENTRY.
//   - prog=1 and enter: shadow digit 0 = digit_in, idx=1, go to PROG.
//     - With DIGITS==1: commit immediately, stay in OPEN.
//   - enter with prog=0: ignored.
//  PROG
//   - enter: shadow digit[idx]=digit_in, idx++.
//   - Commit at idx==DIGITS: code<=shadow in the same cycle as the last enter; idx=0; go to OPEN.
//   - prog deasserted before commit: abort; shadow discarded, code unchanged, idx=0, go to OPEN.
//   - clear: idx=0, stay in PROG.
//   - relock (priority over enter/clear): abort, go to ENTRY.
//  LOCKOUT
//   - Counter runs 0..LOCKOUT_CYCLES-1; all inputs ignored.
//   - On terminal count: go to ENTRY, tries_left=MAX_TRIES, counter=0.
//  Overflow and width rules
//   - idx never exceeds DIGITS.
//   - tries_left saturates at 0 and never wraps.
//   - Digit compare is full DIGIT_W bits.
// TESTING
//  - DIGITS=4, DIGIT_W=4, code 1234: enter 1,2,3,4 -> unlocked=1 exactly 2 cycles after the 4th enter; tries_left=3.
//  - Enter 1,2,3,5 three times with LOCKOUT_CYCLES=20 -> fail_pulse x3; lockout=1 for 20 cycles; then ENTRY with tries_left=3.
//  - Enter 1,2 then clear, then 1,2,3,4 -> unlocked, tries_left stays 3; clear+enter in the same cycle leaves idx unchanged.
//  - In OPEN with prog=1, enter 9,8,7,6 -> relock -> enter 9,8,7,6 -> unlocked; enter 1,2,3,4 -> fail_pulse.
//  - In PROG after 2 digits, drop prog -> code remains 1234.
//  - Assert rst during LOCKOUT and mid-PROG -> all outputs 0 immediately, tries_left=3, code back to 1234.

Source files
------------

// File: rtl/combo_lock_fsm.sv
// Combination-lock controller: collects DIGITS switch entries, checks them against a
// stored code, counts failed attempts with a timed lockout, and allows re-programming while open.
module combo_lock_fsm #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  localparam int IW = $clog2(DIGITS + 1),
  localparam int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter,
  input  logic               clear,
  input  logic               relock,
  input  logic               prog,
  output logic               unlocked,
  output logic               lockout,
  output logic               fail_pulse,
  output logic [IW-1:0]      idx,
  output logic [TW-1:0]      tries_left,
  output logic [2:0]         state_o
);

  localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROG    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // Digit 0 sits in the most significant slice, matching DEFAULT_CODE's layout.
  typedef logic [DIGITS-1:0][DIGIT_W-1:0] code_t;

  state_t               state, state_n;
  code_t                code, code_n, shadow, shadow_n;
  logic [IW-1:0]        idx_n;
  logic                 mismatch, mismatch_n;
  logic [TW-1:0]        tries_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 fail_n, unlocked_n, lockout_n;
  logic [DIGIT_W-1:0]   cur_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENTRY;
      code       <= DEFAULT_CODE;
      shadow     <= '0;
      idx        <= '0;
      mismatch   <= 1'b0;
      tries_left <= TW'(MAX_TRIES);
      cnt        <= '0;
      fail_pulse <= 1'b0;
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state      <= state_n;
      code       <= code_n;
      shadow     <= shadow_n;
      idx        <= idx_n;
      mismatch   <= mismatch_n;
      tries_left <= tries_n;
      cnt        <= cnt_n;
      fail_pulse <= fail_n;
      unlocked   <= unlocked_n;
      lockout    <= lockout_n;
    end
  end

  assign state_o = state;

  always_comb begin
    state_n    = state;
    code_n     = code;
    shadow_n   = shadow;
    idx_n      = idx;
    mismatch_n = mismatch;
    tries_n    = tries_left;
    cnt_n      = cnt;
    fail_n     = 1'b0;
    cur_digit  = '0;
    for (int k = 0; k < DIGITS; k++)
      if (idx == IW'(k)) cur_digit = code[DIGITS-1-k];

    case (state)
      ENTRY: begin
        if (clear) begin
          idx_n      = '0;
          mismatch_n = 1'b0;
        end else if (enter) begin
          mismatch_n = mismatch | (digit_in != cur_digit);
          idx_n      = idx + 1'b1;
          if (idx == IW'(DIGITS - 1)) state_n = CHECK;
        end
      end
      CHECK: begin
        idx_n      = '0;
        mismatch_n = 1'b0;
        if (!mismatch) begin
          state_n = OPEN;
          tries_n = TW'(MAX_TRIES);
        end else begin
          fail_n = 1'b1;
          // Saturating decrement; the last failed try goes straight to lockout.
          if (tries_left <= TW'(1)) begin
            tries_n = '0;
            state_n = LOCKOUT;
          end else begin
            tries_n = tries_left - 1'b1;
            state_n = ENTRY;
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_n = ENTRY;
        end else if (prog && enter) begin
          shadow_n[DIGITS-1] = digit_in;
          if (DIGITS == 1) begin
            code_n = shadow_n;
          end else begin
            idx_n   = IW'(1);
            state_n = PROG;
          end
        end
      end
      PROG: begin
        if (relock) begin
          idx_n   = '0;
          state_n = ENTRY;
        end else if (!prog) begin
          idx_n   = '0;
          state_n = OPEN;
        end else if (clear) begin
          idx_n = '0;
        end else if (enter) begin
          for (int k = 0; k < DIGITS; k++)
            if (idx == IW'(k)) shadow_n[DIGITS-1-k] = digit_in;
          if (idx == IW'(DIGITS - 1)) begin
            code_n  = shadow_n;
            idx_n   = '0;
            state_n = OPEN;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (cnt == CW'(LOCKOUT_CYCLES - 1)) begin
          cnt_n   = '0;
          tries_n = TW'(MAX_TRIES);
          state_n = ENTRY;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ENTRY;
    endcase

    unlocked_n = (state_n == OPEN) || (state_n == PROG);
    lockout_n  = (state_n == LOCKOUT);
  end

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: directed scenarios plus random traffic checked against
// a queue-based model of the lock's rules.
module tb_combo_lock_fsm;

  localparam int LCYC = 20;

  logic       clk = 0;
  logic       rst = 1;
  logic [3:0] digit_in = '0;
  logic       enter = 0, clear = 0, relock = 0, prog = 0;
  logic       unlocked, lockout, fail_pulse;
  logic [2:0] idx;
  logic [1:0] tries_left;
  logic [2:0] state_o;

  int checks = 0;
  int passes = 0;

  combo_lock_fsm #(
    .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(LCYC), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .clear(clear),
    .relock(relock), .prog(prog), .unlocked(unlocked), .lockout(lockout),
    .fail_pulse(fail_pulse), .idx(idx), .tries_left(tries_left), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 entry, 1 check, 2 open, 3 prog, 4 lockout.
  int m_code[4];
  int m_q[$];
  int m_sh[$];
  int m_tries, m_st, m_lock;
  bit m_fail;

  function automatic void model_reset();
    m_code = '{1, 2, 3, 4};
    m_q.delete();
    m_sh.delete();
    m_tries = 3;
    m_st    = 0;
    m_lock  = 0;
    m_fail  = 0;
  endfunction

  function automatic void model_step(bit e, bit c, bit r, bit p, int d);
    bit ok;
    m_fail = 0;
    case (m_st)
      0: if (c) m_q.delete();
         else if (e) begin
           m_q.push_back(d);
           if (m_q.size() == 4) m_st = 1;
         end
      1: begin
        ok = 1;
        for (int k = 0; k < 4; k++) if (m_q[k] != m_code[k]) ok = 0;
        m_q.delete();
        if (ok) begin
          m_st = 2; m_tries = 3;
        end else begin
          m_fail = 1;
          if (m_tries > 0) m_tries--;
          if (m_tries == 0) begin m_st = 4; m_lock = 0; end
          else m_st = 0;
        end
      end
      2: if (r) m_st = 0;
         else if (p && e) begin
           m_sh.delete(); m_sh.push_back(d); m_st = 3;
         end
      3: if (r) begin m_sh.delete(); m_st = 0; end
         else if (!p) begin m_sh.delete(); m_st = 2; end
         else if (c) m_sh.delete();
         else if (e) begin
           m_sh.push_back(d);
           if (m_sh.size() == 4) begin
             for (int k = 0; k < 4; k++) m_code[k] = m_sh[k];
             m_sh.delete();
             m_st = 2;
           end
         end
      4: if (m_lock == LCYC - 1) begin m_st = 0; m_tries = 3; end
         else m_lock++;
      default: m_st = 0;
    endcase
  endfunction

  function automatic int model_idx();
    case (m_st)
      0: return m_q.size();
      1: return 4;
      3: return m_sh.size();
      default: return 0;
    endcase
  endfunction

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic tick(bit e, bit c, bit r, bit p, int d);
    enter = e; clear = c; relock = r; prog = p; digit_in = 4'(d);
    @(posedge clk);
    model_step(e, c, r, p, d);
    #1;
    enter = 0; clear = 0; relock = 0;
  endtask

  task automatic enter4(int a, int b, int c, int d, bit p);
    tick(1, 0, 0, p, a); tick(1, 0, 0, p, b); tick(1, 0, 0, p, c); tick(1, 0, 0, p, d);
  endtask

  task automatic hit_rst();
    #2 rst = 1;
    model_reset();
    #1;
  endtask

  task automatic drop_rst();
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o); else passes++;
    checks++; if ({unlocked, lockout, fail_pulse} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {unlocked, lockout, fail_pulse}); else passes++;
    checks++; if (tries_left !== 2'd3) $display("FAIL reset_tries: got %0d want 3", tries_left); else passes++;
    checks++; if (idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", idx); else passes++;
    model_reset();
    drop_rst();
  endtask

  task automatic test_unlock();
    enter4(1, 2, 3, 4, 0);
    checks++; if (state_o !== 3'd1 || unlocked !== 1'b0)
      $display("FAIL unlock_n1: got state %0d unl %b want 1/0", state_o, unlocked); else passes++;
    tick(0, 0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1 || state_o !== 3'd2)
      $display("FAIL unlock_n2: got unl %b state %0d want 1/2", unlocked, state_o); else passes++;
    checks++; if (tries_left !== 2'd3) $display("FAIL unlock_tries: got %0d want 3", tries_left); else passes++;
  endtask

  task automatic test_lockout();
    int lk;
    tick(0, 0, 1, 0, 0);
    for (int t = 0; t < 3; t++) begin
      enter4(1, 2, 3, 5, 0);
      tick(0, 0, 0, 0, 0);
      checks++; if (fail_pulse !== 1'b1) $display("FAIL lock_fail%0d: got %b want 1", t, fail_pulse); else passes++;
      checks++; if (tries_left !== 2'(2 - t))
        $display("FAIL lock_tries%0d: got %0d want %0d", t, tries_left, 2 - t); else passes++;
      if (t < 2) begin
        tick(0, 0, 0, 0, 0);
        checks++; if (fail_pulse !== 1'b0) $display("FAIL lock_pulse_len%0d: got %b want 0", t, fail_pulse); else passes++;
      end
    end
    lk = lockout ? 1 : 0;
    for (int i = 0; i < 40 && lockout; i++) begin
      tick(1, 1, 1, 1, 1);
      if (lockout) lk++;
    end
    checks++; if (lk != LCYC) $display("FAIL lock_len: got %0d cycles want %0d", lk, LCYC); else passes++;
    checks++; if (state_o !== 3'd0 || tries_left !== 2'd3)
      $display("FAIL lock_exit: got state %0d tries %0d want 0/3", state_o, tries_left); else passes++;
  endtask

  task automatic test_clear();
    tick(1, 0, 0, 0, 1); tick(1, 0, 0, 0, 2);
    checks++; if (idx !== 3'd2) $display("FAIL clear_pre: got idx %0d want 2", idx); else passes++;
    tick(0, 1, 0, 0, 0);
    checks++; if (idx !== 3'd0) $display("FAIL clear_idx: got %0d want 0", idx); else passes++;
    tick(1, 1, 0, 0, 1);
    checks++; if (idx !== 3'd0) $display("FAIL clear_enter: got idx %0d want 0", idx); else passes++;
    enter4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1 || tries_left !== 2'd3)
      $display("FAIL clear_unlock: got unl %b tries %0d want 1/3", unlocked, tries_left); else passes++;
  endtask

  task automatic test_prog();
    tick(1, 0, 0, 1, 9); tick(1, 0, 0, 1, 8); tick(1, 0, 0, 1, 7);
    checks++; if (state_o !== 3'd3 || unlocked !== 1'b1 || idx !== 3'd3)
      $display("FAIL prog_mid: got state %0d unl %b idx %0d want 3/1/3", state_o, unlocked, idx); else passes++;
    tick(1, 0, 0, 1, 6);
    checks++; if (state_o !== 3'd2 || idx !== 3'd0)
      $display("FAIL prog_commit: got state %0d idx %0d want 2/0", state_o, idx); else passes++;
    tick(0, 0, 1, 0, 0);
    checks++; if (state_o !== 3'd0 || unlocked !== 1'b0)
      $display("FAIL prog_relock: got state %0d unl %b want 0/0", state_o, unlocked); else passes++;
    enter4(9, 8, 7, 6, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) $display("FAIL prog_newcode: got unl %b want 1", unlocked); else passes++;
    tick(0, 0, 1, 0, 0);
    enter4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (fail_pulse !== 1'b1 || tries_left !== 2'd2)
      $display("FAIL prog_oldcode: got fail %b tries %0d want 1/2", fail_pulse, tries_left); else passes++;
  endtask

  task automatic test_prog_abort();
    hit_rst();
    drop_rst();
    enter4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 5); tick(1, 0, 0, 1, 6);
    checks++; if (idx !== 3'd2) $display("FAIL abort_idx: got %0d want 2", idx); else passes++;
    tick(0, 0, 0, 0, 0);
    checks++; if (state_o !== 3'd2 || idx !== 3'd0)
      $display("FAIL abort_state: got state %0d idx %0d want 2/0", state_o, idx); else passes++;
    tick(0, 0, 1, 0, 0);
    enter4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) $display("FAIL abort_code: got unl %b want 1", unlocked); else passes++;
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 1, 0, 0);
    for (int t = 0; t < 3; t++) begin
      enter4(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
    end
    checks++; if (lockout !== 1'b1) $display("FAIL rstmid_inlock: got %b want 1", lockout); else passes++;
    hit_rst();
    checks++; if ({unlocked, lockout, fail_pulse, state_o} !== 6'b0 || tries_left !== 2'd3)
      $display("FAIL rstmid_lock: got flags %b state %0d tries %0d want 000/0/3",
               {unlocked, lockout, fail_pulse}, state_o, tries_left); else passes++;
    drop_rst();
    enter4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 0);
    enter4(9, 8, 7, 6, 1);
    tick(1, 0, 0, 1, 1); tick(1, 0, 0, 1, 1);
    hit_rst();
    checks++; if ({unlocked, lockout, fail_pulse, state_o} !== 6'b0 || idx !== 3'd0)
      $display("FAIL rstmid_prog: got flags %b state %0d idx %0d want 000/0/0",
               {unlocked, lockout, fail_pulse}, state_o, idx); else passes++;
    drop_rst();
    enter4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) $display("FAIL rstmid_code: got unl %b want 1", unlocked); else passes++;
  endtask

  task automatic test_random();
    bit e, c, r, p;
    int d;
    int errs;
    errs = 0;
    p = 0;
    hit_rst();
    drop_rst();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 10) p = ~p;
      e = $urandom_range(99) < 60;
      c = $urandom_range(99) < 5;
      r = $urandom_range(99) < 4;
      if (m_st == 0 && m_q.size() < 4 && $urandom_range(99) < 80) d = m_code[m_q.size()];
      else d = $urandom_range(15);
      tick(e, c, r, p, d);
      checks++;
      if (state_o !== 3'(m_st) || unlocked !== (m_st == 2 || m_st == 3) || lockout !== (m_st == 4) ||
          fail_pulse !== m_fail || idx !== 3'(model_idx()) || tries_left !== 2'(m_tries)) begin
        if (errs < 10)
          $display("FAIL rand_cyc%0d: got st %0d unl %b lk %b fp %b idx %0d tr %0d want st %0d fp %b idx %0d tr %0d",
                   i, state_o, unlocked, lockout, fail_pulse, idx, tries_left,
                   m_st, m_fail, model_idx(), m_tries);
        errs++;
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_prog();
    test_prog_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
